// File: rtl/vt_term_pkg.sv
// Shared state encoding, control codes and screen geometry for the VT terminal writer.
// VT_TERM_ESC_EN adds the escape-sequence states to the state enum.
package vt_term_pkg;

  localparam int unsigned TEXT_START = 80;
  localparam int unsigned TEXT_END   = 1999;
  localparam int unsigned ROW_BYTES  = 80;
  localparam int unsigned OFF_W      = 11;
  localparam int unsigned BOFF_W     = 12;

  localparam logic [7:0] CH_BS  = 8'h08;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_FF  = 8'h0C;
  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_ESC = 8'h1B;
  localparam logic [7:0] CH_Y   = 8'h59;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PUT,
    ST_NEWLINE,
    ST_SCR_RD,
    ST_SCR_WR,
    ST_FILL,
    ST_CLEAR
`ifdef VT_TERM_ESC_EN
    ,
    ST_ESC,
    ST_ESC_R,
    ST_ESC_C
`endif
  } state_t;

endpackage

// File: rtl/vt_wb_master.sv
// Single-transfer Wishbone master: one request at a time, with an idle cycle
// forced after every ack so the slave never sees a held strobe.
module vt_wb_master (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        req,
  input  logic [15:0] req_adr,
  input  logic [15:0] req_dat,
  input  logic        req_we,
  input  logic [1:0]  req_sel,
  output logic        done,
  output logic [15:0] rd_dat,
  output logic [15:0] wb_adr_o,
  output logic [15:0] wb_dat_o,
  input  logic [15:0] wb_dat_i,
  output logic        wb_we_o,
  output logic [1:0]  wb_sel_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i
);

  // done doubles as the gap cycle: a request still asserted while done is high is stale.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_we_o  <= 1'b0;
      wb_sel_o <= '0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      done     <= 1'b0;
      rd_dat   <= '0;
    end else begin
      done <= 1'b0;
      if (wb_cyc_o) begin
        if (wb_ack_i) begin
          wb_cyc_o <= 1'b0;
          wb_stb_o <= 1'b0;
          wb_we_o  <= 1'b0;
          done     <= 1'b1;
          rd_dat   <= wb_dat_i;
        end
      end else if (req && !done) begin
        wb_adr_o <= req_adr;
        wb_dat_o <= req_dat;
        wb_we_o  <= req_we;
        wb_sel_o <= req_sel;
        wb_cyc_o <= 1'b1;
        wb_stb_o <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/vt_term_writer.sv
// Character-stream terminal engine writing glyphs into a text-mode screen buffer over Wishbone.
// Define VT_TERM_ESC_EN to add VT52 direct cursor addressing (ESC 'Y' row col).
module vt_term_writer
  import vt_term_pkg::*;
#(
  parameter logic [15:0] BASE_ADR  = 16'h0000,
  parameter int unsigned COLS      = 80,
  parameter int unsigned FIRST_ROW = 1,
  parameter int unsigned LAST_ROW  = 24,
  parameter logic [7:0]  BLANK     = 8'h20
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [7:0]  char_i,
  input  logic        char_valid_i,
  output logic        char_ready_o,
  output logic [15:0] wb_adr_o,
  output logic [15:0] wb_dat_o,
  input  logic [15:0] wb_dat_i,
  output logic        wb_we_o,
  output logic [1:0]  wb_sel_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  output logic [12:0] cursor,
  output logic        busy_o
);

  localparam int unsigned ROW_W = $clog2(LAST_ROW + 1);
  localparam int unsigned COL_W = $clog2(COLS);
  localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(FIRST_ROW);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(LAST_ROW);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(COLS - 1);
  // Word-granular offsets: clear start, last scroll destination, fill start, last text word.
  localparam logic [OFF_W-1:0] CLR_FIRST  = OFF_W'(TEXT_START / 2);
  localparam logic [OFF_W-1:0] SCR_LAST   = OFF_W'((TEXT_END + 1 - ROW_BYTES) / 2 - 1);
  localparam logic [OFF_W-1:0] FILL_FIRST = OFF_W'((TEXT_END + 1 - ROW_BYTES) / 2);
  localparam logic [OFF_W-1:0] FILL_LAST  = OFF_W'((TEXT_END - 1) / 2);

  state_t             state;
  logic [ROW_W-1:0]   row;
  logic [COL_W-1:0]   col;
  logic [OFF_W-1:0]   off;
  logic [7:0]         ch;
  logic               accept;

  logic               bus_req;
  logic               bus_we;
  logic [BOFF_W-1:0]  bus_off;
  logic [15:0]        bus_adr;
  logic [15:0]        bus_dat;
  logic [1:0]         bus_sel;
  logic               bus_done;
  logic [15:0]        bus_rd_dat;

  assign accept = char_valid_i & char_ready_o;
  assign cursor = 13'(row) * 13'(COLS) + 13'(col);

`ifdef VT_TERM_ESC_EN
  function automatic logic [ROW_W-1:0] esc_row(input logic [7:0] v);
    int unsigned r;
    if (v < 8'h20) return ROW_FIRST;
    r = 32'(v) - 32'h20 + FIRST_ROW;
    return (r > LAST_ROW) ? ROW_LAST : ROW_W'(r);
  endfunction

  function automatic logic [COL_W-1:0] esc_col(input logic [7:0] v);
    if (v < 8'h20) return '0;
    return ((32'(v) - 32'h20) > (COLS - 1)) ? COL_LAST : COL_W'(v - 8'h20);
  endfunction
`endif

  // Bus request decode from the current state and offset counter.
  always_comb begin
    bus_req = 1'b0;
    bus_we  = 1'b1;
    bus_off = {off, 1'b0};
    bus_dat = {BLANK, BLANK};
    case (state)
      ST_PUT: begin
        bus_req = 1'b1;
        bus_off = BOFF_W'(cursor);
        bus_dat = {ch, ch};
      end
      ST_SCR_RD: begin
        bus_req = 1'b1;
        bus_we  = 1'b0;
        bus_off = {off, 1'b0} + BOFF_W'(ROW_BYTES);
      end
      ST_SCR_WR: begin
        bus_req = 1'b1;
        bus_dat = bus_rd_dat;
      end
      ST_FILL, ST_CLEAR: bus_req = 1'b1;
      default: ;
    endcase
    bus_adr = BASE_ADR + 16'(bus_off);
    bus_sel = (state == ST_PUT) ? (bus_adr[0] ? 2'b10 : 2'b01) : 2'b11;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state        <= ST_CLEAR;
      row          <= ROW_FIRST;
      col          <= '0;
      off          <= CLR_FIRST;
      ch           <= '0;
      char_ready_o <= 1'b0;
      busy_o       <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            ch <= char_i;
            if (char_i >= 8'h20) begin
              state        <= ST_PUT;
              char_ready_o <= 1'b0;
            end else begin
              case (char_i)
                CH_CR: col <= '0;
                CH_LF: begin
                  state        <= ST_NEWLINE;
                  char_ready_o <= 1'b0;
                end
                CH_BS: if (col != '0) col <= col - 1'b1;
                CH_FF: begin
                  state        <= ST_CLEAR;
                  off          <= CLR_FIRST;
                  char_ready_o <= 1'b0;
                  busy_o       <= 1'b1;
                end
`ifdef VT_TERM_ESC_EN
                CH_ESC: state <= ST_ESC;
`endif
                default: ;
              endcase
            end
          end
        end
        ST_PUT: begin
          if (bus_done) begin
            if (col < COL_LAST) begin
              col          <= col + 1'b1;
              state        <= ST_IDLE;
              char_ready_o <= 1'b1;
            end else begin
              col   <= '0;
              state <= ST_NEWLINE;
            end
          end
        end
        ST_NEWLINE: begin
          if (row < ROW_LAST) begin
            row          <= row + 1'b1;
            state        <= ST_IDLE;
            char_ready_o <= 1'b1;
          end else begin
            off    <= CLR_FIRST;
            state  <= ST_SCR_RD;
            busy_o <= 1'b1;
          end
        end
        ST_SCR_RD: if (bus_done) state <= ST_SCR_WR;
        ST_SCR_WR: begin
          if (bus_done) begin
            if (off == SCR_LAST) begin
              off   <= FILL_FIRST;
              state <= ST_FILL;
            end else begin
              off   <= off + 1'b1;
              state <= ST_SCR_RD;
            end
          end
        end
        ST_FILL, ST_CLEAR: begin
          if (bus_done) begin
            if (off == FILL_LAST) begin
              if (state == ST_CLEAR) begin
                row <= ROW_FIRST;
                col <= '0;
              end
              state        <= ST_IDLE;
              busy_o       <= 1'b0;
              char_ready_o <= 1'b1;
            end else begin
              off <= off + 1'b1;
            end
          end
        end
`ifdef VT_TERM_ESC_EN
        // Escape states keep ready high; each consumes exactly one byte.
        ST_ESC: if (accept) state <= (char_i == CH_Y) ? ST_ESC_R : ST_IDLE;
        ST_ESC_R: begin
          if (accept) begin
            ch    <= char_i;
            state <= ST_ESC_C;
          end
        end
        ST_ESC_C: begin
          if (accept) begin
            row   <= esc_row(ch);
            col   <= esc_col(char_i);
            state <= ST_IDLE;
          end
        end
`endif
        default: begin
          state        <= ST_IDLE;
          char_ready_o <= 1'b1;
          busy_o       <= 1'b0;
        end
      endcase
    end
  end

  vt_wb_master u_wb (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .req      (bus_req),
    .req_adr  (bus_adr),
    .req_dat  (bus_dat),
    .req_we   (bus_we),
    .req_sel  (bus_sel),
    .done     (bus_done),
    .rd_dat   (bus_rd_dat),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_dat_i (wb_dat_i),
    .wb_we_o  (wb_we_o),
    .wb_sel_o (wb_sel_o),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_ack_i (wb_ack_i)
  );

endmodule

// File: tb/tb_vt_term_writer.sv
// Directed bench for vt_term_writer with a 2000-byte Wishbone screen-buffer slave model.
// Set VT_TERM_ESC_EN on both bench and RTL to exercise the escape-sequence path.
module tb_vt_term_writer;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic [7:0]  char_i;
  logic        char_valid_i;
  logic        char_ready_o;
  logic [15:0] wb_adr_o;
  logic [15:0] wb_dat_o;
  logic [15:0] wb_dat_i = '0;
  logic        wb_we_o;
  logic [1:0]  wb_sel_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_ack_i = 1'b0;
  logic [12:0] cursor;
  logic        busy_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  mem [0:1999];
  logic        pat_req;
  logic        prev_ack = 1'b0;
  int          wait_cnt = 0;
  int          txn = 0;
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          bad_adr = 0;
  int          proto_err = 0;
  int          last_wr_adr = 0;
  int          last_rd_adr = 0;
  logic [15:0] last_wr_dat = '0;
  logic [1:0]  last_wr_sel = '0;
  int          rb_viol = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  vt_term_writer dut (
    .wb_clk_i     (wb_clk_i),
    .wb_rst_i     (wb_rst_i),
    .char_i       (char_i),
    .char_valid_i (char_valid_i),
    .char_ready_o (char_ready_o),
    .wb_adr_o     (wb_adr_o),
    .wb_dat_o     (wb_dat_o),
    .wb_dat_i     (wb_dat_i),
    .wb_we_o      (wb_we_o),
    .wb_sel_o     (wb_sel_o),
    .wb_cyc_o     (wb_cyc_o),
    .wb_stb_o     (wb_stb_o),
    .wb_ack_i     (wb_ack_i),
    .cursor       (cursor),
    .busy_o       (busy_o)
  );

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 7 + 3);
  endfunction

  // Screen-buffer slave: 0..2 wait states, acks while strobe is high (re-acks a held strobe).
  always @(posedge wb_clk_i) begin
    int a;
    int wa;
    if (pat_req)
      for (int i = 0; i < 2000; i++) mem[i] <= pat(i);
    if (wb_rst_i) begin
      wb_ack_i <= 1'b0;
      prev_ack <= 1'b0;
      wait_cnt <= 0;
    end else begin
      prev_ack <= wb_ack_i;
      wb_ack_i <= 1'b0;
      if ((prev_ack && wb_stb_o) || (wb_cyc_o != wb_stb_o)) proto_err <= proto_err + 1;
      if (wb_cyc_o && wb_stb_o && !wb_ack_i) begin
        if (wait_cnt >= txn % 3) begin
          wb_ack_i <= 1'b1;
          wait_cnt <= 0;
          txn      <= txn + 1;
          a  = int'(wb_adr_o);
          wa = a - (a % 2);
          if (a < 80 || a > 1999) begin
            bad_adr <= bad_adr + 1;
          end else if (wb_we_o) begin
            if (wb_sel_o[0]) mem[wa]     <= wb_dat_o[7:0];
            if (wb_sel_o[1]) mem[wa + 1] <= wb_dat_o[15:8];
            wr_cnt      <= wr_cnt + 1;
            last_wr_adr <= a;
            last_wr_dat <= wb_dat_o;
            last_wr_sel <= wb_sel_o;
          end else begin
            wb_dat_i    <= {mem[wa + 1], mem[wa]};
            rd_cnt      <= rd_cnt + 1;
            last_rd_adr <= a;
          end
        end else begin
          wait_cnt <= wait_cnt + 1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic int text_blank_errs();
    int e = 0;
    for (int i = 80; i < 2000; i++) if (mem[i] !== 8'h20) e++;
    return e;
  endfunction

  function automatic int row0_errs();
    int e = 0;
    for (int i = 0; i < 80; i++) if (mem[i] !== pat(i)) e++;
    return e;
  endfunction

  function automatic int scroll_errs();
    int e = 0;
    logic [7:0] x;
    for (int i = 0; i < 2000; i++) begin
      x = (i < 80) ? pat(i) : (i < 1920) ? pat(i + 80) : 8'h20;
      if (mem[i] !== x) e++;
    end
    return e;
  endfunction

  task automatic send(input logic [7:0] c);
    int n = 0;
    char_i       = c;
    char_valid_i = 1'b1;
    while (!char_ready_o && n < 40000) begin
      @(negedge wb_clk_i);
      n++;
    end
    @(posedge wb_clk_i);
    #1;
    char_valid_i = 1'b0;
    check("send_ready", 32'(n < 40000), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge wb_clk_i);
    while (!(char_ready_o && !busy_o) && n < 40000) begin
      if (char_ready_o && busy_o) rb_viol++;
      @(negedge wb_clk_i);
      n++;
    end
    check({tag, "_idle"}, 32'(n < 40000), 32'd1);
  endtask

  task automatic send_idle(input logic [7:0] c, input string tag);
    send(c);
    wait_idle(tag);
  endtask

  initial begin
    int w0, r0, v0, e, n;
    wb_rst_i     = 1'b1;
    char_i       = '0;
    char_valid_i = 1'b0;
    pat_req      = 1'b1;
    repeat (2) @(posedge wb_clk_i);
    #1 pat_req = 1'b0;
    @(negedge wb_clk_i);

    // Reset state
    check("rst_cyc", 32'(wb_cyc_o), 32'd0);
    check("rst_stb", 32'(wb_stb_o), 32'd0);
    check("rst_we", 32'(wb_we_o), 32'd0);
    check("rst_adr", 32'(wb_adr_o), 32'd0);
    check("rst_sel", 32'(wb_sel_o), 32'd0);
    check("rst_ready", 32'(char_ready_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd1);
    check("rst_cursor", 32'(cursor), 32'd80);

    // Initial clear after reset release
    w0 = wr_cnt; r0 = rd_cnt;
    wb_rst_i = 1'b0;
    wait_idle("clr0");
    check("clr0_writes", 32'(wr_cnt - w0), 32'd960);
    check("clr0_reads", 32'(rd_cnt - r0), 32'd0);
    check("clr0_last_adr", 32'(last_wr_adr), 32'd1998);
    check("clr0_last_sel", 32'(last_wr_sel), 32'd3);
    check("clr0_mem", 32'(text_blank_errs()), 32'd0);
    check("clr0_row0", 32'(row0_errs()), 32'd0);
    check("clr0_cursor", 32'(cursor), 32'd80);
    check("clr0_busy", 32'(busy_o), 32'd0);
    check("clr0_ready", 32'(char_ready_o), 32'd1);

    // Byte writes: even then odd lane
    send_idle(8'h41, "put_a");
    check("put_a_adr", 32'(last_wr_adr), 32'd80);
    check("put_a_dat", 32'(last_wr_dat), 32'h4141);
    check("put_a_sel", 32'(last_wr_sel), 32'd1);
    check("put_a_cursor", 32'(cursor), 32'd81);
    send_idle(8'h42, "put_b");
    check("put_b_adr", 32'(last_wr_adr), 32'd81);
    check("put_b_dat", 32'(last_wr_dat), 32'h4242);
    check("put_b_sel", 32'(last_wr_sel), 32'd2);
    check("put_b_cursor", 32'(cursor), 32'd82);
    check("put_ab_mem", 32'({mem[80], mem[81], mem[82]}), 32'h414220);

    // Full row wrap from column 0 of row 1
    send_idle(8'h0D, "cr1");
    check("cr1_cursor", 32'(cursor), 32'd80);
    w0 = wr_cnt; r0 = rd_cnt;
    for (int i = 0; i < 80; i++) send_idle(8'(8'h61 + i % 26), "row");
    e = 0;
    for (int i = 0; i < 80; i++) if (mem[80 + i] !== 8'(8'h61 + i % 26)) e++;
    check("wrap_mem", 32'(e), 32'd0);
    check("wrap_writes", 32'(wr_cnt - w0), 32'd80);
    check("wrap_reads", 32'(rd_cnt - r0), 32'd0);
    check("wrap_cursor", 32'(cursor), 32'd160);

    // Control codes: BS at column 0, BS mid-row, CR, ignored code
    send_idle(8'h08, "bs0");
    check("bs0_cursor", 32'(cursor), 32'd160);
    send_idle(8'h78, "x");
    send_idle(8'h79, "y");
    check("xy_cursor", 32'(cursor), 32'd162);
    send_idle(8'h08, "bs1");
    check("bs1_cursor", 32'(cursor), 32'd161);
    send_idle(8'h0D, "cr2");
    check("cr2_cursor", 32'(cursor), 32'd160);
    w0 = wr_cnt;
    send_idle(8'h01, "ctl");
    check("ctl_cursor", 32'(cursor), 32'd160);
    check("ctl_writes", 32'(wr_cnt - w0), 32'd0);

`ifdef VT_TERM_ESC_EN
    send(8'h1B); send(8'h59); send(8'h22); send_idle(8'h2A, "esc1");
    check("esc_cursor", 32'(cursor), 32'd250);
    send(8'h1B); send(8'h59); send(8'h7F); send_idle(8'h7F, "esc2");
    check("esc_clamp", 32'(cursor), 32'd1999);
    w0 = wr_cnt;
    send(8'h1B); send_idle(8'h51, "esc3");
    check("esc_discard", 32'(cursor), 32'd1999);
    check("esc_discard_wr", 32'(wr_cnt - w0), 32'd0);
`else
    send_idle(8'h1B, "esc_ign");
    check("esc_ign_cursor", 32'(cursor), 32'd160);
`endif

    // Form feed clears and homes
    w0 = wr_cnt;
    send_idle(8'h0C, "ff");
    check("ff_writes", 32'(wr_cnt - w0), 32'd960);
    check("ff_mem", 32'(text_blank_errs()), 32'd0);
    check("ff_cursor", 32'(cursor), 32'd80);

    // Move to row 24, column 5, then scroll with LF
    for (int i = 0; i < 23; i++) send_idle(8'h0A, "lf");
    check("lf_cursor", 32'(cursor), 32'd1920);
    for (int i = 0; i < 5; i++) send_idle(8'h71, "q");
    check("q_cursor", 32'(cursor), 32'd1925);
    @(negedge wb_clk_i);
    pat_req = 1'b1;
    @(negedge wb_clk_i);
    pat_req = 1'b0;
    w0 = wr_cnt; r0 = rd_cnt; v0 = rb_viol;
    send_idle(8'h0A, "scroll");
    check("scroll_reads", 32'(rd_cnt - r0), 32'd920);
    check("scroll_writes", 32'(wr_cnt - w0), 32'd960);
    check("scroll_last_rd", 32'(last_rd_adr), 32'd1998);
    check("scroll_last_wr", 32'(last_wr_adr), 32'd1998);
    check("scroll_mem", 32'(scroll_errs()), 32'd0);
    check("scroll_ready_busy", 32'(rb_viol - v0), 32'd0);
    check("scroll_cursor", 32'(cursor), 32'd1925);

    // Reset in the middle of a scroll transfer
    send(8'h0A);
    repeat (100) @(negedge wb_clk_i);
    n = 0;
    while (!wb_cyc_o && n < 1000) begin
      @(negedge wb_clk_i);
      n++;
    end
    check("mid_cyc_seen", 32'(wb_cyc_o), 32'd1);
    check("mid_busy", 32'(busy_o), 32'd1);
    wb_rst_i = 1'b1;
    #1;
    check("mid_rst_cyc", 32'(wb_cyc_o), 32'd0);
    check("mid_rst_stb", 32'(wb_stb_o), 32'd0);
    check("mid_rst_cursor", 32'(cursor), 32'd80);
    check("mid_rst_ready", 32'(char_ready_o), 32'd0);
    repeat (2) @(negedge wb_clk_i);
    w0 = wr_cnt; r0 = rd_cnt;
    wb_rst_i = 1'b0;
    wait_idle("clr1");
    check("clr1_writes", 32'(wr_cnt - w0), 32'd960);
    check("clr1_reads", 32'(rd_cnt - r0), 32'd0);
    check("clr1_mem", 32'(text_blank_errs()), 32'd0);
    check("clr1_cursor", 32'(cursor), 32'd80);

    check("row0_final", 32'(row0_errs()), 32'd0);
    check("bad_adr", 32'(bad_adr), 32'd0);
    check("proto_err", 32'(proto_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
